// File: rtl/slime_anim_pkg.sv
// Shared types and defaults for the slime death-animation block.
package slime_anim_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DYING = 2'd1,
    DONE  = 2'd2
  } slime_anim_state_e;

  localparam int COORD_W        = 10;
  localparam int POS_W          = COORD_W + 1;
  localparam int DEF_SPRITE_W   = 32;
  localparam int DEF_SPRITE_H   = 16;
  localparam int DEF_TILE_SHIFT = 4;

endpackage

// File: rtl/slime_death_chan.sv
// One slime corpse: FSM, tick/frame counters, position latch and pixel hit test.
module slime_death_chan
  import slime_anim_pkg::*;
#(
  parameter int NUM_FRAMES   = 5,
  parameter int TICKS_PER_FR = 8,
  parameter int SPRITE_W     = DEF_SPRITE_W,
  parameter int SPRITE_H     = DEF_SPRITE_H,
  parameter int TILE_SHIFT   = DEF_TILE_SHIFT,
  parameter int HOLD_LAST    = 1,
  localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
  localparam int TW = (TICKS_PER_FR > 1) ? $clog2(TICKS_PER_FR) : 1
) (
  input  logic               frame_clk,
  input  logic               RESET,
  input  logic [COORD_W-1:0] draw_x,
  input  logic [COORD_W-1:0] draw_y,
  input  logic [COORD_W-1:0] row,
  input  logic [COORD_W-1:0] col,
  input  logic               dead,
  input  logic               respawn,
  output logic [FW-1:0]      frame,
  output logic               display,
  output logic               anim_done,
  output logic               hit
);

  slime_anim_state_e state, state_nx;
  logic [TW-1:0]    tick, tick_nx;
  logic [FW-1:0]    frame_nx;
  logic [POS_W-1:0] pos_x, pos_y, pos_x_nx, pos_y_nx;
  logic [POS_W-1:0] px, py;

  always_ff @(posedge frame_clk or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      tick  <= '0;
      frame <= '0;
      pos_x <= '0;
      pos_y <= '0;
    end else begin
      state <= state_nx;
      tick  <= tick_nx;
      frame <= frame_nx;
      pos_x <= pos_x_nx;
      pos_y <= pos_y_nx;
    end
  end

  always_comb begin
    state_nx = state;
    tick_nx  = tick;
    frame_nx = frame;
    pos_x_nx = pos_x;
    pos_y_nx = pos_y;
    // respawn wins over a simultaneous dead; dead is seen again next tick
    if (respawn) begin
      state_nx = IDLE;
      tick_nx  = '0;
      frame_nx = '0;
    end else begin
      case (state)
        IDLE: begin
          if (dead) begin
            state_nx = DYING;
            tick_nx  = '0;
            frame_nx = '0;
            pos_x_nx = POS_W'({1'b0, col} << TILE_SHIFT);
            pos_y_nx = POS_W'({1'b0, row} << TILE_SHIFT);
          end
        end
        DYING: begin
          if (tick == TW'(TICKS_PER_FR - 1)) begin
            tick_nx = '0;
            if (frame == FW'(NUM_FRAMES - 1)) state_nx = DONE;
            else frame_nx = frame + FW'(1);
          end else begin
            tick_nx = tick + TW'(1);
          end
        end
        DONE:    state_nx = DONE;
        default: state_nx = IDLE;
      endcase
    end
  end

  assign display   = (state == DYING) || ((state == DONE) && (HOLD_LAST != 0));
  assign anim_done = (state == DONE);

  // 11-bit compare keeps sprites at the right/bottom edge from wrapping to 0
  assign px  = {1'b0, draw_x};
  assign py  = {1'b0, draw_y};
  assign hit = display
             && (px >= pos_x) && (px < pos_x + POS_W'(SPRITE_W))
             && (py >= pos_y) && (py < pos_y + POS_W'(SPRITE_H));

endmodule

// File: rtl/slime_death_anim.sv
// Death-animation controller for N_SLIME slimes plus corpse-pixel priority encoder.
// Optional respawn input enabled by defining SLIME_RESPAWN_EN.
module slime_death_anim
  import slime_anim_pkg::*;
#(
  parameter int N_SLIME      = 3,
  parameter int NUM_FRAMES   = 5,
  parameter int TICKS_PER_FR = 8,
  parameter int SPRITE_W     = DEF_SPRITE_W,
  parameter int SPRITE_H     = DEF_SPRITE_H,
  parameter int TILE_SHIFT   = DEF_TILE_SHIFT,
  parameter int HOLD_LAST    = 1,
  localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
  localparam int IW = (N_SLIME > 1) ? $clog2(N_SLIME) : 1
) (
  input  logic               frame_clk,
  input  logic               RESET,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  input  logic [COORD_W-1:0] slim_row [N_SLIME],
  input  logic [COORD_W-1:0] slim_col [N_SLIME],
  input  logic [N_SLIME-1:0] dead,
`ifdef SLIME_RESPAWN_EN
  input  logic [N_SLIME-1:0] respawn,
`endif
  output logic [N_SLIME-1:0] slimDeadOn,
  output logic [FW-1:0]      frame [N_SLIME],
  output logic [N_SLIME-1:0] display,
  output logic [N_SLIME-1:0] anim_done,
  output logic               any_on,
  output logic [IW-1:0]      on_idx
);

  logic [N_SLIME-1:0] respawn_int;

`ifdef SLIME_RESPAWN_EN
  assign respawn_int = respawn;
`else
  assign respawn_int = '0;
`endif

  for (genvar i = 0; i < N_SLIME; i++) begin : g_chan
    slime_death_chan #(
      .NUM_FRAMES  (NUM_FRAMES),
      .TICKS_PER_FR(TICKS_PER_FR),
      .SPRITE_W    (SPRITE_W),
      .SPRITE_H    (SPRITE_H),
      .TILE_SHIFT  (TILE_SHIFT),
      .HOLD_LAST   (HOLD_LAST)
    ) u_chan (
      .frame_clk(frame_clk),
      .RESET    (RESET),
      .draw_x   (DrawX),
      .draw_y   (DrawY),
      .row      (slim_row[i]),
      .col      (slim_col[i]),
      .dead     (dead[i]),
      .respawn  (respawn_int[i]),
      .frame    (frame[i]),
      .display  (display[i]),
      .anim_done(anim_done[i]),
      .hit      (slimDeadOn[i])
    );
  end

  // descending scan so the lowest hitting index is the one that sticks
  always_comb begin
    any_on = |slimDeadOn;
    on_idx = '0;
    for (int i = N_SLIME - 1; i >= 0; i--) begin
      if (slimDeadOn[i]) on_idx = IW'(i);
    end
  end

endmodule

// File: tb/tb_slime_death_anim.sv
// Bench for slime_death_anim: directed scenarios plus randomized traffic against an age-based model.
module tb_slime_death_anim;

  localparam int N    = 3;
  localparam int NF   = 5;
  localparam int TPF  = 8;
  localparam int SW   = 32;
  localparam int SH   = 16;
  localparam int TS   = 4;
  localparam int HOLD = 1;
  localparam int FW   = 3;
  localparam int IW   = 2;
  localparam int OW   = 3 * N + 1 + IW + N * FW;

  logic          frame_clk = 1'b0;
  logic          RESET = 1'b1;
  logic [9:0]    DrawX = '0;
  logic [9:0]    DrawY = '0;
  logic [9:0]    slim_row [N];
  logic [9:0]    slim_col [N];
  logic [N-1:0]  dead = '0;
  logic [N-1:0]  respawn_s = '0;
  logic [N-1:0]  slimDeadOn;
  logic [FW-1:0] frame [N];
  logic [N-1:0]  display;
  logic [N-1:0]  anim_done;
  logic          any_on;
  logic [IW-1:0] on_idx;

  int n_checks = 0;
  int n_fail   = 0;

  // model: a corpse is just "active" plus its age in clocks since the death edge
  bit m_act [N];
  int m_age [N];
  int m_px  [N];
  int m_py  [N];

  logic [N*FW-1:0] obs_fr;
  logic [OW-1:0]   obs;

  slime_death_anim dut (
    .frame_clk (frame_clk),
    .RESET     (RESET),
    .DrawX     (DrawX),
    .DrawY     (DrawY),
    .slim_row  (slim_row),
    .slim_col  (slim_col),
    .dead      (dead),
`ifdef SLIME_RESPAWN_EN
    .respawn   (respawn_s),
`endif
    .slimDeadOn(slimDeadOn),
    .frame     (frame),
    .display   (display),
    .anim_done (anim_done),
    .any_on    (any_on),
    .on_idx    (on_idx)
  );

  always #5 frame_clk = ~frame_clk;

  always_comb begin
    obs_fr = '0;
    for (int i = 0; i < N; i++) obs_fr[i*FW +: FW] = frame[i];
  end
  assign obs = {display, anim_done, slimDeadOn, any_on, on_idx, obs_fr};

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_act[i] = 0;
      m_age[i] = 0;
      m_px[i]  = 0;
      m_py[i]  = 0;
    end
  endfunction

  function automatic void model_clock();
    if (RESET) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (respawn_s[i]) begin
        m_act[i] = 0;
        m_age[i] = 0;
      end else if (!m_act[i]) begin
        if (dead[i]) begin
          m_act[i] = 1;
          m_age[i] = 0;
          m_px[i]  = int'(slim_col[i]) * (1 << TS);
          m_py[i]  = int'(slim_row[i]) * (1 << TS);
        end
      end else if (m_age[i] < 10000) begin
        m_age[i]++;
      end
    end
  endfunction

  function automatic logic [OW-1:0] exp_all();
    logic [N-1:0]    e_disp, e_done, e_on;
    logic            e_any;
    logic [IW-1:0]   e_idx;
    logic [N*FW-1:0] e_fr;
    int fr, x, y;
    bit dn;
    e_disp = '0; e_done = '0; e_on = '0; e_fr = '0; e_idx = '0;
    x = int'(DrawX);
    y = int'(DrawY);
    for (int i = 0; i < N; i++) begin
      dn = m_act[i] && (m_age[i] >= NF * TPF);
      fr = m_act[i] ? m_age[i] / TPF : 0;
      if (fr > NF - 1) fr = NF - 1;
      e_done[i] = dn;
      e_disp[i] = m_act[i] && (!dn || HOLD != 0);
      e_fr[i*FW +: FW] = FW'(fr);
      e_on[i] = e_disp[i] && x >= m_px[i] && x < m_px[i] + SW
                          && y >= m_py[i] && y < m_py[i] + SH;
    end
    e_any = |e_on;
    for (int i = N - 1; i >= 0; i--) if (e_on[i]) e_idx = IW'(i);
    return {e_disp, e_done, e_on, e_any, e_idx, e_fr};
  endfunction

  task automatic step();
    @(posedge frame_clk);
    model_clock();
    @(negedge frame_clk);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    dead = '0;
    respawn_s = '0;
    for (int i = 0; i < N; i++) begin
      slim_row[i] = '0;
      slim_col[i] = '0;
    end
    model_reset();
    step();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    RESET = 1'b1;
    #1;
    n_checks++;
    if (obs !== exp_all()) begin
      n_fail++;
      $display("FAIL reset_all: got %h want %h", obs, exp_all());
    end
    n_checks++;
    if (display !== 3'b000 || anim_done !== 3'b000 || any_on !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got disp=%b done=%b any=%b want 0", display, anim_done, any_on);
    end
    @(negedge frame_clk);
    RESET = 1'b0;
  endtask

  task automatic test_single_hit();
    int xs [6] = '{80, 112, 111, 79, 100, 100};
    int ys [6] = '{48, 48, 63, 48, 64, 47};
    bit hs [6] = '{1, 0, 1, 0, 0, 0};
    do_reset();
    slim_row[1] = 10'd3;
    slim_col[1] = 10'd5;
    dead[1] = 1'b1;
    step();
    n_checks++;
    if (display[1] !== 1'b1 || frame[1] !== 3'd0) begin
      n_fail++;
      $display("FAIL hit_latency: got disp=%b frame=%0d want 1/0", display[1], frame[1]);
    end
    for (int k = 0; k < 6; k++) begin
      DrawX = 10'(xs[k]);
      DrawY = 10'(ys[k]);
      #1;
      n_checks++;
      if (slimDeadOn[1] !== hs[k] || obs !== exp_all()) begin
        n_fail++;
        $display("FAIL hit_edge x=%0d y=%0d: got on=%b all=%h want on=%b all=%h",
                 xs[k], ys[k], slimDeadOn[1], obs, hs[k], exp_all());
      end
    end
  endtask

  task automatic test_full_anim();
    do_reset();
    slim_row[0] = 10'd1;
    slim_col[0] = 10'd2;
    dead[0] = 1'b1;
    DrawX = 10'd40;
    DrawY = 10'd20;
    for (int c = 0; c < 46; c++) begin
      step();
      n_checks++;
      if (obs !== exp_all() || frame[0] !== 3'((c / TPF > NF - 1) ? NF - 1 : c / TPF)) begin
        n_fail++;
        $display("FAIL anim_cycle %0d: got %h want %h", c, obs, exp_all());
      end
      if (c == 39 || c == 40) begin
        n_checks++;
        if (anim_done[0] !== (c == 40) || display[0] !== 1'(HOLD != 0 || c == 39)) begin
          n_fail++;
          $display("FAIL anim_done_edge %0d: got done=%b disp=%b", c, anim_done[0], display[0]);
        end
      end
    end
  endtask

  task automatic test_pos_latch();
    do_reset();
    slim_col[0] = 10'd2;
    dead[0] = 1'b1;
    step();
    dead[0] = 1'b0;
    repeat (3) step();
    slim_col[0] = 10'd9;
    dead[0] = 1'b1;
    step();
    dead[0] = 1'b0;
    step();
    DrawY = 10'd0;
    DrawX = 10'd32;
    #1;
    n_checks++;
    if (slimDeadOn[0] !== 1'b1 || frame[0] !== 3'd0 || obs !== exp_all()) begin
      n_fail++;
      $display("FAIL latch_old_pos: got on=%b frame=%0d want 1/0", slimDeadOn[0], frame[0]);
    end
    DrawX = 10'd144;
    #1;
    n_checks++;
    if (slimDeadOn[0] !== 1'b0 || obs !== exp_all()) begin
      n_fail++;
      $display("FAIL latch_new_pos: got on=%b want 0", slimDeadOn[0]);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    dead = 3'b101;
    repeat (17) step();
    n_checks++;
    if (frame[0] !== 3'd2 || obs !== exp_all()) begin
      n_fail++;
      $display("FAIL pre_reset_frame: got %0d want 2", frame[0]);
    end
    #2;
    RESET = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (display !== 3'b000 || frame[0] !== 3'd0 || frame[2] !== 3'd0 || obs !== exp_all()) begin
      n_fail++;
      $display("FAIL async_reset: got %h want %h", obs, exp_all());
    end
    @(negedge frame_clk);
    RESET = 1'b0;
    step();
    n_checks++;
    if (display !== 3'b101 || frame[0] !== 3'd0 || obs !== exp_all()) begin
      n_fail++;
      $display("FAIL restart: got disp=%b frame=%0d want 101/0", display, frame[0]);
    end
  endtask

  task automatic test_overlap();
    do_reset();
    slim_row[0] = 10'd4; slim_col[0] = 10'd10;
    slim_row[1] = 10'd4; slim_col[1] = 10'd20;
    slim_row[2] = 10'd4; slim_col[2] = 10'd10;
    dead = 3'b111;
    step();
    DrawX = 10'd165;
    DrawY = 10'd70;
    #1;
    n_checks++;
    if (any_on !== 1'b1 || on_idx !== 2'd0 || slimDeadOn !== 3'b101 || obs !== exp_all()) begin
      n_fail++;
      $display("FAIL overlap: got any=%b idx=%0d on=%b want 1/0/101", any_on, on_idx, slimDeadOn);
    end
    do_reset();
    slim_col[1] = 10'd63;
    dead[1] = 1'b1;
    step();
    DrawX = 10'd5;
    DrawY = 10'd3;
    #1;
    n_checks++;
    if (any_on !== 1'b0 || slimDeadOn !== 3'b000 || obs !== exp_all()) begin
      n_fail++;
      $display("FAIL edge_nowrap: got any=%b on=%b want 0/000", any_on, slimDeadOn);
    end
    DrawX = 10'd1010;
    #1;
    n_checks++;
    if (any_on !== 1'b1 || on_idx !== 2'd1 || obs !== exp_all()) begin
      n_fail++;
      $display("FAIL edge_hit: got any=%b idx=%0d want 1/1", any_on, on_idx);
    end
  endtask

`ifdef SLIME_RESPAWN_EN
  task automatic test_respawn();
    do_reset();
    slim_col[2] = 10'd1;
    dead[2] = 1'b1;
    repeat (41) step();
    n_checks++;
    if (anim_done[2] !== 1'b1 || obs !== exp_all()) begin
      n_fail++;
      $display("FAIL respawn_pre_done: got %b want 1", anim_done[2]);
    end
    respawn_s[2] = 1'b1;
    step();
    respawn_s[2] = 1'b0;
    n_checks++;
    if (display[2] !== 1'b0 || anim_done[2] !== 1'b0 || frame[2] !== 3'd0 || obs !== exp_all()) begin
      n_fail++;
      $display("FAIL respawn_idle: got disp=%b done=%b want 0/0", display[2], anim_done[2]);
    end
    step();
    n_checks++;
    if (display[2] !== 1'b1 || frame[2] !== 3'd0 || obs !== exp_all()) begin
      n_fail++;
      $display("FAIL respawn_redie: got disp=%b frame=%0d want 1/0", display[2], frame[2]);
    end
  endtask
`endif

  task automatic test_random();
    int k, x, y;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        dead[i] = ($urandom_range(7, 0) == 0);
        slim_row[i] = 10'($urandom_range(63, 0));
        slim_col[i] = 10'($urandom_range(63, 0));
`ifdef SLIME_RESPAWN_EN
        respawn_s[i] = ($urandom_range(40, 0) == 0);
`endif
      end
      RESET = ($urandom_range(150, 0) == 0);
      step();
      RESET = 1'b0;
      k = int'($urandom_range(N - 1, 0));
      x = m_px[k] + int'($urandom_range(40, 0)) - 4;
      y = m_py[k] + int'($urandom_range(24, 0)) - 4;
      if (x < 0) x = 0;
      if (x > 1023) x = 1023;
      if (y < 0) y = 0;
      if (y > 1023) y = 1023;
      DrawX = 10'(x);
      DrawY = 10'(y);
      #1;
      n_checks++;
      if (obs !== exp_all()) begin
        n_fail++;
        $display("FAIL random_cycle %0d: got %h want %h", c, obs, exp_all());
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      slim_row[i] = '0;
      slim_col[i] = '0;
    end
    model_reset();
    @(negedge frame_clk);
    test_reset();
    test_single_hit();
    test_full_anim();
    test_pos_latch();
    test_async_reset();
    test_overlap();
`ifdef SLIME_RESPAWN_EN
    test_respawn();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
